pce_pad_scanner: RTL and testbench
==================================

Name: pce_pad_scanner

Overview:
- Console-side joypad port controller for the PC Engine pad bus; sits directly downstream of the uPD65005 multitap.
- Drives the multitap's CLR/SEL inputs and reads its 4-bit D_OUT nibble stream.
- Assembles 8 button bits per pad, for NUM_PADS pads, into a double-buffered register image for the CPU side.
- Supports single-shot and auto-repeat scanning.

Parameters:
- NUM_PADS, 5, pads scanned per pass (1..5).
- CLR_CYCLES, 2, cycles CLR is held high at scan start (>=1).
- SETTLE_CYCLES, 4, cycles SEL is held constant per nibble before sampling (>=1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  scan request, sampled in IDLE only.
- AUTO  in  1  1 = restart the scan on the cycle after DONE.
- CLR  out  1  to multitap CLR.
- SEL  out  1  to multitap SEL.
- D_IN  in  4  from multitap D_OUT; button bits are active-low.
- BUSY  out  1  high while a scan is in progress.
- DONE  out  1  one-cycle pulse when a scan completes.
- PAD_DATA  out  8*NUM_PADS  published image; pad n in bits [8n+7:8n], n=0 is pad 1; bit order RS21LDRU; 1 = pressed.
- PAD_VALID  out  1  set after the first completed scan.

Behaviour:
- Reset (async, RESET=1): state IDLE, CLR=0, SEL=1, BUSY=0, DONE=0, PAD_DATA=0, PAD_VALID=0, shadow buffer=0, pad index=0, counter=0.
- States: IDLE, CLRP, LO, HI, FIN.
- IDLE: SEL=1, CLR=0. START=1 -> CLRP; CLR and BUSY go high on the next cycle.
- CLRP: CLR=1, SEL=1 for CLR_CYCLES cycles, then -> LO with pad index=0 and CLR=0.
- LO: SEL=1 for SETTLE_CYCLES cycles. On the edge ending the last cycle, shadow[idx][3:0] <= ~D_IN. Then -> HI.
- HI: SEL=0 for SETTLE_CYCLES cycles. On the edge ending the last cycle, shadow[idx][7:4] <= ~D_IN.
  - If idx < NUM_PADS-1: idx+1, -> LO. The SEL 0->1 edge advances the multitap to the next pad.
  - Otherwise -> FIN.
- FIN (one cycle): SEL=1, CLR=0, BUSY=0, DONE=1. PAD_DATA <= shadow (atomic, all bits on the same edge). PAD_VALID <= 1.
  - Next state: CLRP if AUTO=1, else IDLE.
  - START is ignored in FIN.
- Latency: CLR rises 1 cycle after START is sampled. DONE is high exactly CLR_CYCLES + 2*NUM_PADS*SETTLE_CYCLES + 1 cycles after that; with defaults, 43 cycles after START is sampled.
- PAD_DATA never changes except at FIN or reset. Partial scans are never visible.
- START while BUSY or in FIN: ignored, not queued.
- AUTO sampled only in FIN. Dropping AUTO mid-scan finishes the current scan, then goes to IDLE.
- Reset mid-scan: immediate abort to reset values, including CLR=0 and SEL=1. The shadow buffer is discarded.
- Pad index counter is wide enough for NUM_PADS-1. The settle counter is wide enough for max(CLR_CYCLES, SETTLE_CYCLES)-1. Neither wraps beyond its terminal value.

Test Plan:
1. Reset values: assert RESET mid-clock -> immediately CLR=0, SEL=1, BUSY=0, DONE=0, PAD_DATA=0, PAD_VALID=0.
2. Single scan with multitap + 5 pad models, raw pad patterns E7, DB, BD, 7E, 6C; pulse START:
   - CLR high cycles 1-2; DONE pulse at cycle 43.
   - PAD_DATA=40'h9381422418, PAD_VALID=1, BUSY low at the DONE cycle.
3. START pulsed at cycle 10 of a busy scan -> no restart; DONE only at 43; next cycle IDLE.
4. RESET asserted at cycle 20 of a scan whose prior image is 40'h9381422418 -> PAD_DATA=0, PAD_VALID=0, SEL=1, CLR=0. A subsequent START completes normally.
5. AUTO=1, pad 1 changed from E7 to FF between scans:
   - Second CLR rises the cycle after the first DONE.
   - PAD_DATA[7:0] stays 18 until the second DONE, then becomes 00.
6. NUM_PADS=1, SETTLE_CYCLES=1: DONE at cycle 5 after START; exactly one SEL low pulse (1 cycle); PAD_DATA=8'h18 for pad E7.

Source files
------------

// File: rtl/pce_pad_scanner_if.sv
// Pad-port bundle between the scanner, the CPU-side request logic and the multitap.
// master = scanner side, slave = host/multitap side.
interface pce_pad_scanner_if #(
  parameter int NUM_PADS = 5
);
  logic                  start;
  logic                  auto;
  logic                  clr;
  logic                  sel;
  logic [3:0]            d_in;
  logic                  busy;
  logic                  done;
  logic [8*NUM_PADS-1:0] pad_data;
  logic                  pad_valid;

  modport master (
    input  start, auto, d_in,
    output clr, sel, busy, done, pad_data, pad_valid
  );

  modport slave (
    output start, auto, d_in,
    input  clr, sel, busy, done, pad_data, pad_valid
  );
endinterface

// File: rtl/pce_pad_scanner.sv
// PC Engine pad port controller: drives multitap CLR/SEL, gathers two nibbles per pad
// into a shadow buffer and publishes the whole image atomically when a scan completes.
module pce_pad_scanner #(
  parameter int NUM_PADS      = 5,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pce_pad_scanner_if.master  bus
);
  localparam int MAXC = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PADS - 1);

  typedef enum logic [2:0] {IDLE, CLRP, LO, HI, FIN} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [NUM_PADS-1:0][7:0] shadow;
  logic [NUM_PADS-1:0][7:0] shadow_nxt;
  logic                     sample_lo;
  logic                     sample_hi;

  assign sample_lo = (state == LO) && (cnt == SET_LAST);
  assign sample_hi = (state == HI) && (cnt == SET_LAST);

  // Buttons arrive active-low; store them inverted so 1 = pressed.
  always_comb begin
    shadow_nxt = shadow;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (idx == IW'(p)) begin
        if (sample_lo) shadow_nxt[p][3:0] = ~bus.d_in;
        if (sample_hi) shadow_nxt[p][7:4] = ~bus.d_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shadow        <= '0;
      bus.clr       <= 1'b0;
      bus.sel       <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pad_data  <= '0;
      bus.pad_valid <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= CLRP;
            cnt      <= '0;
            bus.clr  <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        CLRP: begin
          if (cnt == CLR_LAST) begin
            state   <= LO;
            cnt     <= '0;
            idx     <= '0;
            bus.clr <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LO: begin
          if (cnt == SET_LAST) begin
            state   <= HI;
            cnt     <= '0;
            bus.sel <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (cnt == SET_LAST) begin
            cnt     <= '0;
            bus.sel <= 1'b1;  // rising SEL steps the multitap to the next pad
            if (idx == IDX_LAST) begin
              // Publish from shadow_nxt so the final nibble lands on the same edge.
              state         <= FIN;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.pad_data  <= shadow_nxt;
              bus.pad_valid <= 1'b1;
            end else begin
              state <= LO;
              idx   <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          if (bus.auto) begin
            state    <= CLRP;
            cnt      <= '0;
            bus.clr  <= 1'b1;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pce_pad_scanner.sv
// Bench for pce_pad_scanner: two configurations (5 pads/settle 4, 1 pad/settle 1)
// driven by shared stimulus, each behind a multitap model, checked against a timeline model.
module tb_pce_pad_scanner;
  localparam int CA = 2, NA = 5, SA = 4, LA = CA + 2*NA*SA + 1;
  localparam int CB = 2, NB = 1, SB = 1, LB = CB + 2*NB*SB + 1;

  logic clk = 1'b0;
  logic rst;
  logic start, auto;
  logic [7:0] raw [5];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pce_pad_scanner_if #(.NUM_PADS(NA)) bus_a ();
  pce_pad_scanner_if #(.NUM_PADS(NB)) bus_b ();

  pce_pad_scanner #(.NUM_PADS(NA), .CLR_CYCLES(CA), .SETTLE_CYCLES(SA))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pce_pad_scanner #(.NUM_PADS(NB), .CLR_CYCLES(CB), .SETTLE_CYCLES(SB))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.start = start;
  assign bus_b.start = start;
  assign bus_a.auto  = auto;
  assign bus_b.auto  = auto;

  // Multitap: CLR rewinds to pad 1, each SEL rising edge advances; SEL=1 -> direction nibble.
  int ptr_a = 0;
  int ptr_b = 0;
  always @(posedge bus_a.sel or posedge bus_a.clr)
    if (bus_a.clr) ptr_a <= 0; else ptr_a <= ptr_a + 1;
  always @(posedge bus_b.sel or posedge bus_b.clr)
    if (bus_b.clr) ptr_b <= 0; else ptr_b <= ptr_b + 1;

  always_comb begin
    bus_a.d_in = 4'hF;
    if (ptr_a < NA) bus_a.d_in = bus_a.sel ? raw[ptr_a][3:0] : raw[ptr_a][7:4];
  end
  always_comb begin
    bus_b.d_in = 4'hF;
    if (ptr_b < NB) bus_b.d_in = bus_b.sel ? raw[ptr_b][3:0] : raw[ptr_b][7:4];
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Timeline model: pos = cycles since START was taken (0 = idle, len = done cycle).
  function automatic int step(input int pos, input int len, input logic st, input logic au);
    if (pos == 0)   return st ? 1 : 0;
    if (pos == len) return au ? 1 : 0;
    return pos + 1;
  endfunction

  // {clr, sel, busy, done} implied by a timeline position.
  function automatic logic [3:0] expect_ctl(input int pos, input int c, input int n, input int s);
    int k;
    if (pos == 0) return 4'b0100;
    if (pos <= c) return 4'b1110;
    if (pos <= c + 2*n*s) begin
      k = pos - c - 1;
      return {1'b0, ((k / s) % 2) == 0, 1'b1, 1'b0};
    end
    return 4'b0101;
  endfunction

  int pos_a, pos_b;
  logic [8*NA-1:0] img_a;
  logic [8*NB-1:0] img_b;
  logic vld_a, vld_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_a <= 0; pos_b <= 0;
      img_a <= '0; img_b <= '0;
      vld_a <= 1'b0; vld_b <= 1'b0;
    end else begin
      pos_a <= step(pos_a, LA, start, auto);
      pos_b <= step(pos_b, LB, start, auto);
      if (step(pos_a, LA, start, auto) == LA) begin
        for (int p = 0; p < NA; p++) img_a[8*p +: 8] <= ~raw[p];
        vld_a <= 1'b1;
      end
      if (step(pos_b, LB, start, auto) == LB) begin
        img_b <= ~raw[0];
        vld_b <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_ctl",   {bus_a.clr, bus_a.sel, bus_a.busy, bus_a.done}, expect_ctl(pos_a, CA, NA, SA));
      chk("a_data",  bus_a.pad_data, img_a);
      chk("a_valid", bus_a.pad_valid, vld_a);
      chk("b_ctl",   {bus_b.clr, bus_b.sel, bus_b.busy, bus_b.done}, expect_ctl(pos_b, CB, NB, SB));
      chk("b_data",  bus_b.pad_data, img_b);
      chk("b_valid", bus_b.pad_valid, vld_b);
    end
  end

  task automatic reset_vals(input string nm);
    chk({nm, "_clr"},   bus_a.clr, 1'b0);
    chk({nm, "_sel"},   bus_a.sel, 1'b1);
    chk({nm, "_busy"},  bus_a.busy, 1'b0);
    chk({nm, "_done"},  bus_a.done, 1'b0);
    chk({nm, "_data"},  bus_a.pad_data, 40'h0);
    chk({nm, "_valid"}, bus_a.pad_valid, 1'b0);
    chk({nm, "_bdata"}, bus_b.pad_data, 8'h0);
  endtask

  // Leaves the caller at the falling edge inside cycle 1 of the scan.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int selb_low;

  initial begin
    rst = 1'b1; start = 1'b0; auto = 1'b0;
    raw[0] = 8'hE7; raw[1] = 8'hDB; raw[2] = 8'hBD; raw[3] = 8'h7E; raw[4] = 8'h6C;
    #1;
    reset_vals("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single scan, both configurations.
    selb_low = 0;
    pulse_start();
    for (int c = 1; c <= 44; c++) begin
      if (c <= 3) chk("t2_clr", bus_a.clr, c <= 2);
      if (c <= 10 && !bus_b.sel) selb_low++;
      if (c == 5) begin
        chk("t6_done", bus_b.done, 1'b1);
        chk("t6_data", bus_b.pad_data, 8'h18);
      end
      chk("t2_done", bus_a.done, c == 43);
      if (c == 43) begin
        chk("t2_data",  bus_a.pad_data, 40'h9381422418);
        chk("t2_valid", bus_a.pad_valid, 1'b1);
        chk("t2_busy",  bus_a.busy, 1'b0);
      end
      @(negedge clk);
    end
    chk("t6_sel_pulses", selb_low, 1);

    // START during a busy scan is dropped.
    pulse_start();
    for (int c = 1; c <= 44; c++) begin
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      chk("t3_done", bus_a.done, c == 43);
      if (c == 44) chk("t3_idle", {bus_a.busy, bus_a.clr}, 2'b00);
      @(negedge clk);
    end

    // Async reset in the middle of a scan.
    pulse_start();
    for (int c = 1; c < 20; c++) @(negedge clk);
    chk("t4_prior", bus_a.pad_data, 40'h9381422418);
    #2 rst = 1'b1;
    #1 reset_vals("t4");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int c = 1; c <= 43; c++) begin
      chk("t4_done", bus_a.done, c == 43);
      if (c == 43) chk("t4_data", bus_a.pad_data, 40'h9381422418);
      @(negedge clk);
    end

    // Auto-repeat with pad 1 released between scans.
    auto = 1'b1;
    pulse_start();
    for (int c = 1; c <= 88; c++) begin
      if (c == 43) chk("t5_done1", bus_a.done, 1'b1);
      if (c == 44) chk("t5_clr2", bus_a.clr, 1'b1);
      if (c == 45) raw[0] = 8'hFF;
      if (c == 50) auto = 1'b0;
      if (c == 60 || c == 85) chk("t5_hold", bus_a.pad_data[7:0], 8'h18);
      if (c == 86) begin
        chk("t5_done2", bus_a.done, 1'b1);
        chk("t5_new", bus_a.pad_data[7:0], 8'h00);
      end
      if (c == 87 || c == 88) chk("t5_idle", {bus_a.busy, bus_a.clr}, 2'b00);
      @(negedge clk);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 6) == 0;
      auto  = ($urandom % 5) == 0;
      if (pos_a == 0 && pos_b == 0 && ($urandom % 3) == 0)
        raw[$urandom_range(4, 0)] = 8'($urandom);
      if (($urandom % 400) == 0) begin
        #2 rst = 1'b1;
        #1 reset_vals("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
